nlp16_bus_target: RTL

- Responder end of the nlp16af core memory bus; the core is the initiator.
- The core drives o_wr, o_rd, o_address and o_bus. It samples i_bus combinationally in the same cycle, and the bus has no wait states.
- This block serves the following:
  - a word-addressed RAM;
  - a console TX FIFO drained through a valid/ready byte stream;
  - a free-running cycle timer;
  - a sticky bus-error flag.
- Sits at top level beside the core. Memory-bus ports connect one-to-one.

---
 rtl/common_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 35 +++
 rtl/nlp16_bus_target.sv | 63 ++++++
 3 files changed

// File: rtl/common_pkg.sv
// common_pkg: nlp16 bus target address map, status bit indices and address decode
package common_pkg;
  localparam logic [15:0] ADDR_CON_DATA   = 16'hFF00;
  localparam logic [15:0] ADDR_CON_STAT   = 16'hFF01;
  localparam logic [15:0] ADDR_TIMER      = 16'hFF02;
  localparam logic [15:0] ADDR_TIMER_CTRL = 16'hFF03;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  typedef enum logic [2:0] {
    SEL_RAM, SEL_CON_DATA, SEL_CON_STAT, SEL_TIMER, SEL_TIMER_CTRL, SEL_NONE
  } bus_sel_e;
  function automatic bus_sel_e decode(input logic [15:0] addr, input int ram_aw);
    return (32'(addr) < (32'd1 << ram_aw)) ? SEL_RAM :
           (addr == ADDR_CON_DATA)   ? SEL_CON_DATA :
           (addr == ADDR_CON_STAT)   ? SEL_CON_STAT :
           (addr == ADDR_TIMER)      ? SEL_TIMER :
           (addr == ADDR_TIMER_CTRL) ? SEL_TIMER_CTRL : SEL_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with extra-MSB pointers; head drives 0 when empty
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/nlp16_bus_target.sv
// nlp16_bus_target: zero-wait-state responder for the nlp16af core bus
// serving RAM, a console TX FIFO, a cycle timer and a sticky error flag
module nlp16_bus_target
  import common_pkg::*;
#(
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [15:0] i_address,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_bus_err
);
  bus_sel_e    sel;
  logic        we, push, pop, full, empty, enable, ovf, ctrl_wr;
  logic [15:0] count, stat;
  logic [15:0] ram [2**RAM_AW];
  assign sel        = decode(i_address, RAM_AW);
  // a colliding read/write is treated as a read only
  assign we         = i_wr && !i_rd;
  assign ctrl_wr    = we && sel == SEL_TIMER_CTRL;
  assign push       = we && sel == SEL_CON_DATA;
  assign pop        = o_tx_valid && i_tx_ready;
  assign o_tx_valid = !empty;
  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(push), .pop(pop),
    .wdata(i_wdata[7:0]), .rdata(o_tx_data), .full(full), .empty(empty)
  );
  always_ff @(posedge i_clk)
    if (we && sel == SEL_RAM) ram[i_address[RAM_AW-1:0]] <= i_wdata;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count     <= '0;
      enable    <= 1'b0;
      ovf       <= 1'b0;
      o_bus_err <= 1'b0;
    end else begin
      count     <= (ctrl_wr && i_wdata[1]) ? '0 : enable ? count + 16'd1 : count;
      enable    <= ctrl_wr ? i_wdata[0] : enable;
      ovf       <= (push && full && !pop) ||
                   (ovf && !(we && sel == SEL_CON_STAT && i_wdata[STAT_OVF]));
      o_bus_err <= o_bus_err || ((i_wr || i_rd) && (sel == SEL_NONE || (i_wr && i_rd)));
    end
  end
  always_comb begin
    stat             = '0;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL]  = full;
    stat[STAT_OVF]   = ovf;
    o_rdata = !i_rd                  ? '0 :
              sel == SEL_RAM         ? ram[i_address[RAM_AW-1:0]] :
              sel == SEL_CON_STAT    ? stat :
              sel == SEL_TIMER       ? count :
              sel == SEL_TIMER_CTRL  ? {15'b0, enable} : '0;
  end
endmodule
